sprite_renderer: RTL and testbench



---
 rtl/sprite_renderer_if.sv | 22 ++
 rtl/sprite_renderer.sv | 124 ++++++++++++
 tb/tb_sprite_renderer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_renderer_if.sv
// Pixel-side bundle between the VGA timing block and the sprite renderer:
// scan counters and pause in, colour and frame status out.
interface sprite_renderer_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       pause;
  logic [2:0] out_red;
  logic [2:0] out_green;
  logic [1:0] out_blue;
  logic       frame_tick;
  logic [7:0] bounce_count;

  modport master (
    output hc, vc, pause,
    input  out_red, out_green, out_blue, frame_tick, bounce_count
  );

  modport slave (
    input  hc, vc, pause,
    output out_red, out_green, out_blue, frame_tick, bounce_count
  );
endinterface

// File: rtl/sprite_renderer.sv
// Bouncing solid-sprite pixel source feeding a VGA timing block, one pixel of lookahead.
// Optional macro CHECKER_BG_EN replaces the solid background with a 16x16 checkerboard.
module sprite_renderer #(
  parameter int         SPRITE_W     = 32,
  parameter int         SPRITE_H     = 32,
  parameter int         SPEED        = 2,
  parameter int         INIT_X       = 100,
  parameter int         INIT_Y       = 100,
  parameter logic [7:0] SPRITE_COLOR = 8'hE0,
  parameter logic [7:0] BG_COLOR     = 8'h03
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  sprite_renderer_if.slave  bus
);

  localparam logic [10:0] SW    = 11'(SPRITE_W);
  localparam logic [10:0] SH    = 11'(SPRITE_H);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] H_ACT = 11'd640;
  localparam logic [10:0] V_ACT = 11'd480;

  if (SPRITE_W > 639 || SPRITE_H > 479 || SPEED == 0 ||
      INIT_X + SPRITE_W > 640 || INIT_Y + SPRITE_H > 480) begin : g_param_check
    $error("sprite_renderer: illegal sprite geometry or speed");
  end

  typedef struct packed {
    logic [10:0] pos;
    logic        neg;
    logic        bounce;
  } axis_t;

  // One frame of motion on one axis; clamps to the wall and reverses on contact.
  function automatic axis_t step_axis(input logic [10:0] pos, input logic neg,
                                      input logic [10:0] size, input logic [10:0] limit);
    axis_t r;
    r = '{pos: pos, neg: neg, bounce: 1'b0};
    if (!neg) begin
      if (pos + SPD + size >= limit) begin
        r.pos    = limit - size;
        r.neg    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + SPD;
      end
    end else if (pos < SPD) begin
      r.pos    = 11'd0;
      r.neg    = 1'b0;
      r.bounce = 1'b1;
    end else begin
      r.pos = pos - SPD;
    end
    return r;
  endfunction

  logic [10:0] x, y;
  logic        dx_neg, dy_neg;
  logic [7:0]  colour_q, bounce_q;
  logic        tick_q;

  logic [9:0]  nh, nv;
  logic [10:0] nh_w, nv_w;
  logic        in_sprite, frame_evt;
  logic [7:0]  bg, colour_nxt;
  axis_t       step_x, step_y;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nh = (bus.hc == 10'd799) ? 10'd0 : bus.hc + 10'd1;
    nv = bus.vc;
    if (bus.hc == 10'd799) nv = (bus.vc == 10'd524) ? 10'd0 : bus.vc + 10'd1;
  end

  assign nh_w      = {1'b0, nh};
  assign nv_w      = {1'b0, nv};
  assign in_sprite = (nh_w >= x) && (nh_w < x + SW) && (nv_w >= y) && (nv_w < y + SH);
  assign frame_evt = (bus.hc == 10'd0) && (bus.vc == 10'd480);
  assign step_x    = step_axis(x, dx_neg, SW, H_ACT);
  assign step_y    = step_axis(y, dy_neg, SH, V_ACT);

`ifdef CHECKER_BG_EN
  assign bg = (nh[4] ^ nv[4]) ? ~BG_COLOR : BG_COLOR;
`else
  assign bg = BG_COLOR;
`endif

  always_comb begin
    colour_nxt = bg;
    if (nh_w >= H_ACT || nv_w >= V_ACT) colour_nxt = 8'h00;
    else if (in_sprite)                 colour_nxt = SPRITE_COLOR;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= 8'h00;
      tick_q   <= 1'b0;
      bounce_q <= 8'h00;
      x        <= 11'(INIT_X);
      y        <= 11'(INIT_Y);
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b0;
    end else begin
      colour_q <= colour_nxt;
      tick_q   <= frame_evt;
      // Position only moves on the first blanking line, so a frame never tears.
      if (frame_evt && !bus.pause) begin
        x      <= step_x.pos;
        dx_neg <= step_x.neg;
        y      <= step_y.pos;
        dy_neg <= step_y.neg;
        if (step_x.bounce || step_y.bounce) bounce_q <= bounce_q + 8'd1;
      end
    end
  end

  assign bus.out_red      = colour_q[7:5];
  assign bus.out_green    = colour_q[4:2];
  assign bus.out_blue     = colour_q[1:0];
  assign bus.frame_tick   = tick_q;
  assign bus.bounce_count = bounce_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: three instances (default, right-wall, corner)
// share one set of counters driven directly by the bench.
module tb_sprite_renderer;

  logic       vgaclk = 1'b0;
  logic       rst_n;
  logic [9:0] hc, vc;
  logic       pause;
  int         checks = 0;
  int         errors = 0;

  sprite_renderer_if if_d ();
  sprite_renderer_if if_b ();
  sprite_renderer_if if_c ();

  assign if_d.hc = hc;  assign if_d.vc = vc;  assign if_d.pause = pause;
  assign if_b.hc = hc;  assign if_b.vc = vc;  assign if_b.pause = pause;
  assign if_c.hc = hc;  assign if_c.vc = vc;  assign if_c.pause = pause;

  sprite_renderer u_dflt (.vgaclk(vgaclk), .rst_n(rst_n), .bus(if_d.slave));
  sprite_renderer #(.INIT_X(606)) u_wall (.vgaclk(vgaclk), .rst_n(rst_n), .bus(if_b.slave));
  sprite_renderer #(.INIT_X(607), .INIT_Y(447)) u_corner (.vgaclk(vgaclk), .rst_n(rst_n), .bus(if_c.slave));

  logic [7:0] col_d, col_b, col_c;
  assign col_d = {if_d.out_red, if_d.out_green, if_d.out_blue};
  assign col_b = {if_b.out_red, if_b.out_green, if_b.out_blue};
  assign col_c = {if_c.out_red, if_c.out_green, if_c.out_blue};

  always #20 vgaclk = ~vgaclk;

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Background expected at a visible pixel for the build in use.
  function automatic logic [7:0] bg_at(input int h, input int v);
    logic [9:0] hh, vv;
    hh = 10'(h);
    vv = 10'(v);
`ifdef CHECKER_BG_EN
    return (hh[4] ^ vv[4]) ? 8'hFC : 8'h03;
`else
    return (hh[4] ^ vv[4]) ? 8'h03 : 8'h03;
`endif
  endfunction

  // Present the scan position just before (h,v); after the edge the DUT shows (h,v).
  task automatic probe(input string tag, input int sel, input int h, input int v,
                       input logic [7:0] exp);
    logic [7:0] got;
    if (h == 0) begin
      hc = 10'd799;
      vc = (v == 0) ? 10'd524 : 10'(v - 1);
    end else begin
      hc = 10'(h - 1);
      vc = 10'(v);
    end
    @(posedge vgaclk);
    #1;
    got = (sel == 0) ? col_d : (sel == 1) ? col_b : col_c;
    check(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // One frame update edge; the tick must last exactly one cycle.
  task automatic frame(input string tag);
    hc = 10'd0;
    vc = 10'd480;
    @(posedge vgaclk);
    #1;
    check({tag, "_tick"}, {31'd0, if_d.frame_tick}, 32'd1);
    hc = 10'd1;
    @(posedge vgaclk);
    #1;
    check({tag, "_tick_low"}, {31'd0, if_d.frame_tick}, 32'd0);
  endtask

  initial begin
    int nonzero;
    rst_n = 1'b0;
    pause = 1'b0;
    hc    = 10'd0;
    vc    = 10'd98;
    nonzero = 0;

    // Sweep the counters through the sprite rows while reset is held.
    for (int i = 0; i < 3200; i++) begin
      @(negedge vgaclk);
      if (col_d != 8'h00 || if_d.frame_tick || if_d.bounce_count != 8'h00) nonzero++;
      if (hc == 10'd799) begin
        hc = 10'd0;
        vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
      end else begin
        hc = hc + 10'd1;
      end
    end
    check("reset_quiet", nonzero, 0);

    @(negedge vgaclk);
    rst_n = 1'b1;
    probe("pre_rst_sprite", 0, 115, 102, 8'hE0);
    #5 rst_n = 1'b0;
    #1;
    check("async_rst_colour", {24'd0, col_d}, 32'd0);
    @(negedge vgaclk);
    rst_n = 1'b1;

    probe("tl_corner", 0, 100, 100, 8'hE0);
    probe("br_corner", 0, 131, 131, 8'hE0);
    probe("left_of",   0, 99,  100, bg_at(99, 100));
    probe("right_of",  0, 132, 100, bg_at(132, 100));
    probe("below",     0, 100, 132, bg_at(100, 132));
    probe("last_vis_h",  0, 639, 0,   bg_at(639, 0));
    probe("first_hblank",0, 640, 0,   8'h00);
    probe("last_vis_v",  0, 0,   479, bg_at(0, 479));
    probe("first_vblank",0, 0,   480, 8'h00);
    probe("last_blank",  0, 799, 524, 8'h00);
    probe("origin",      0, 0,   0,   bg_at(0, 0));
    probe("wall_init",   1, 606, 100, 8'hE0);
    probe("corner_init", 2, 638, 478, 8'hE0);

    frame("f1");
    probe("d_f1_in",   0, 102, 102, 8'hE0);
    probe("d_f1_out",  0, 101, 101, bg_at(101, 101));
    probe("d_f1_far",  0, 133, 133, 8'hE0);
    probe("w_f1_left", 1, 608, 102, 8'hE0);
    probe("w_f1_edge", 1, 639, 102, 8'hE0);
    probe("w_f1_out",  1, 607, 102, bg_at(607, 102));
    check("w_f1_bounces", {24'd0, if_b.bounce_count}, 32'd1);
    probe("c_f1_tl",   2, 608, 448, 8'hE0);
    probe("c_f1_br",   2, 639, 479, 8'hE0);
    probe("c_f1_left", 2, 607, 448, bg_at(607, 448));
    probe("c_f1_up",   2, 608, 447, bg_at(608, 447));
    check("c_f1_bounces", {24'd0, if_c.bounce_count}, 32'd1);

    frame("f2");
    probe("w_f2_left", 1, 606, 104, 8'hE0);
    probe("w_f2_out",  1, 638, 104, bg_at(638, 104));
    check("w_f2_bounces", {24'd0, if_b.bounce_count}, 32'd1);
    probe("c_f2_tl",   2, 606, 446, 8'hE0);
    probe("c_f2_left", 2, 605, 446, bg_at(605, 446));
    probe("c_f2_up",   2, 606, 445, bg_at(606, 445));
    check("c_f2_bounces", {24'd0, if_c.bounce_count}, 32'd1);

    // Restart from reset positions, then hold pause across three updates.
    @(negedge vgaclk);
    rst_n = 1'b0;
    @(negedge vgaclk);
    rst_n = 1'b1;
    pause = 1'b1;
    frame("p1");
    frame("p2");
    frame("p3");
    probe("p_tl",     0, 100, 100, 8'hE0);
    probe("p_left",   0, 99,  100, bg_at(99, 100));
    probe("p_up",     0, 100, 99,  bg_at(100, 99));
    probe("p_corner", 2, 607, 447, 8'hE0);
    check("p_bounces", {24'd0, if_c.bounce_count}, 32'd0);

    pause = 1'b0;
    frame("r1");
    probe("r_in",     0, 102, 102, 8'hE0);
    probe("r_out",    0, 101, 101, bg_at(101, 101));
    probe("r_corner", 2, 608, 448, 8'hE0);
    check("r_bounces", {24'd0, if_c.bounce_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
